// File: rtl/wb_reg_bank.sv
// wb_reg_bank: Wishbone classic single-beat slave with a 256-byte register window.
//   CFG_i  (0x00+4i) RW config words driven onto conf_out, with a one-cycle conf_udp pulse per write
//   STAT_i (0x40+4i) RO status words sampled from conf_in
//   CNT 0x80, CMP 0x84, CTRL 0x88 {prescale[15:8], ie[1], en[0]}, IRQ 0x8C (bit0 match, W1C)
// Ports:
//   wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, wb_adr_i   bus request
//   wb_ack_o, wb_stall_o, wb_dat_o                              bus response
//   conf_in / conf_out / conf_udp   per-channel status in, config out, update strobes
//   irq_o                    level interrupt = IRQ.match & CTRL.ie, registered
module wb_reg_bank #(
    parameter logic [31:0] BASE_ADDRESS       = 32'h3000_0000,
    parameter int          NUM_CHANNELS       = 4,
    parameter logic [7:0]  CNT_RESET_PRESCALE = 8'd0
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_we_i,
    input  logic [3:0]                   wb_sel_i,
    input  logic [31:0]                  wb_dat_i,
    input  logic [31:0]                  wb_adr_i,
    output logic                         wb_ack_o,
    output logic                         wb_stall_o,
    output logic [31:0]                  wb_dat_o,
    input  logic [32*NUM_CHANNELS-1:0]   conf_in,
    output logic [32*NUM_CHANNELS-1:0]   conf_out,
    output logic [NUM_CHANNELS-1:0]      conf_udp,
    output logic                         irq_o
);

    localparam logic [4:0] L_NCH = 5'(NUM_CHANNELS);

    // Byte-lane merge: lane n of the result comes from wr when sel[n] is set.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] wr_v,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) begin
                res[8*n +: 8] = wr_v[8*n +: 8];
            end else begin
                res[8*n +: 8] = old_v[8*n +: 8];
            end
        end
        return res;
    endfunction

    logic                        r_ack;
    logic [31:0]                 r_dat;
    logic [32*NUM_CHANNELS-1:0]  r_cfg;
    logic [NUM_CHANNELS-1:0]     r_udp;
    logic [31:0]                 r_cnt;
    logic [31:0]                 r_cmp;
    logic [7:0]                  r_presc;
    logic [7:0]                  r_prescale;
    logic                        r_en;
    logic                        r_ie;
    logic                        r_match;
    logic                        r_irq;

    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic [5:0]  w_word;
    logic [3:0]  w_chan;
    logic        w_cfg_wr;
    logic        w_cnt_wr;
    logic        w_cmp_wr;
    logic        w_ctrl_wr;
    logic        w_irq_clr;
    logic        w_tick;
    logic [31:0] w_cnt_inc;
    logic        w_match_set;
    logic [31:0] w_rdata;
    logic [31:0] w_cfg_arr  [16];
    logic [31:0] w_stat_arr [16];
    logic        w_unused;

    // The ~r_ack term keeps a strobe held across the ack cycle from being accepted twice.
    assign w_hit     = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDRESS[31:8]);
    assign w_acc     = w_hit & ~r_ack;
    assign w_wr      = w_acc & wb_we_i;
    assign w_rd      = w_acc & ~wb_we_i;
    assign w_word    = wb_adr_i[7:2];
    assign w_chan    = w_word[3:0];
    assign w_unused  = &{1'b0, wb_adr_i[1:0]};

    assign w_cfg_wr  = w_wr & (w_word[5:4] == 2'b00) & ({1'b0, w_chan} < L_NCH);
    assign w_cnt_wr  = w_wr & (w_word == 6'h20);
    assign w_cmp_wr  = w_wr & (w_word == 6'h21);
    assign w_ctrl_wr = w_wr & (w_word == 6'h22);
    assign w_irq_clr = w_wr & (w_word == 6'h23) & wb_sel_i[0] & wb_dat_i[0];

    // A prescaler that ended up above a freshly lowered prescale wraps at once instead of running to 255.
    assign w_tick      = r_en & (r_presc >= r_prescale);
    assign w_cnt_inc   = r_cnt + 32'd1;
    // Only a timer increment can raise match; a bus write to CNT in the same cycle cancels the increment.
    assign w_match_set = w_tick & ~w_cnt_wr & (w_cnt_inc == r_cmp);

    // Channels beyond NUM_CHANNELS read as zero, so the mux can index all 16 slots safely.
    for (genvar g = 0; g < 16; g++) begin : g_chan
        if (g < NUM_CHANNELS) begin : g_live
            assign w_cfg_arr[g]  = r_cfg[32*g +: 32];
            assign w_stat_arr[g] = conf_in[32*g +: 32];
        end else begin : g_hole
            assign w_cfg_arr[g]  = 32'd0;
            assign w_stat_arr[g] = 32'd0;
        end
    end

    // Read data mux over the register window; holes return zero.
    always_comb begin
        w_rdata = 32'd0;
        case (w_word[5:4])
            2'b00: w_rdata = w_cfg_arr[w_chan];
            2'b01: w_rdata = w_stat_arr[w_chan];
            2'b10: begin
                case (w_chan)
                    4'h0:    w_rdata = r_cnt;
                    4'h1:    w_rdata = r_cmp;
                    4'h2:    w_rdata = {16'd0, r_prescale, 6'd0, r_ie, r_en};
                    4'h3:    w_rdata = {31'd0, r_match};
                    default: w_rdata = 32'd0;
                endcase
            end
            default: w_rdata = 32'd0;
        endcase
    end

    // Bus handshake, read data capture and config registers with their update strobes.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
            r_cfg <= '0;
            r_udp <= '0;
        end else begin
            r_ack <= w_hit & ~r_ack;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
            r_udp <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_cfg_wr && (w_chan == 4'(i))) begin
                    r_cfg[32*i +: 32] <= f_merge(r_cfg[32*i +: 32], wb_dat_i, wb_sel_i);
                    r_udp[i]          <= 1'b1;
                end
            end
        end
    end

    // Timer: prescaler, counter, compare and control registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt      <= 32'd0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_presc    <= 8'd0;
            r_prescale <= CNT_RESET_PRESCALE;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
        end else begin
            if (w_cnt_wr) begin
                r_cnt   <= f_merge(r_cnt, wb_dat_i, wb_sel_i);
                r_presc <= 8'd0;
            end else if (w_tick) begin
                r_cnt   <= w_cnt_inc;
                r_presc <= 8'd0;
            end else if (r_en) begin
                r_presc <= r_presc + 8'd1;
            end else begin
                r_presc <= 8'd0;
            end
            if (w_cmp_wr) begin
                r_cmp <= f_merge(r_cmp, wb_dat_i, wb_sel_i);
            end
            if (w_ctrl_wr) begin
                if (wb_sel_i[0]) begin
                    r_en <= wb_dat_i[0];
                    r_ie <= wb_dat_i[1];
                end
                if (wb_sel_i[1]) begin
                    r_prescale <= wb_dat_i[15:8];
                end
            end
        end
    end

    // Match flag (set beats W1C) and the registered interrupt level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_match <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_irq_clr) begin
                r_match <= 1'b0;
            end
            r_irq <= r_match & r_ie;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_stall_o = 1'b0;
    assign wb_dat_o   = r_dat;
    assign conf_out   = r_cfg;
    assign conf_udp   = r_udp;
    assign irq_o      = r_irq;

endmodule

// File: doc/wb_reg_bank.md
Name: wb_reg_bank

Overview:
- Parametrised Wishbone classic slave; successor to the single-register config/counter slave.
- Provides NUM_CHANNELS read/write config registers, each with a per-channel update strobe.
- Provides NUM_CHANNELS read-only status registers, plus a prescaled 32-bit timer with compare-match interrupt.
- Sits on the user-project Wishbone bus; drives config into downstream cores and samples their status.

Parameters:
BASE_ADDRESS, 32'h3000_0000, window base; the window is 256 bytes, so BASE_ADDRESS[7:0] must be 0.
NUM_CHANNELS, 4, number of config/status channel pairs; legal range 1..16.
CNT_RESET_PRESCALE, 8'd0, reset value of the prescale field (divisor = field + 1).

Ports:
wb_clk_i  in  1  bus clock; the only clock in the block
wb_rst_i  in  1  synchronous, active-high reset
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte selects
wb_dat_i  in  32  write data
wb_adr_i  in  32  byte address
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  tied 0
wb_dat_o  out  32  read data
conf_in  in  32*NUM_CHANNELS  status words; channel i occupies bits [32i+31:32i]
conf_out  out  32*NUM_CHANNELS  config words, same packing as conf_in
conf_udp  out  NUM_CHANNELS  one-cycle update pulse per channel
irq_o  out  1  timer interrupt, level

Behaviour:
- Clock and reset: wb_clk_i is the only clock. wb_rst_i is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_dat_o=0, conf_out=0, conf_udp=0, CNT=0, CMP=32'hFFFF_FFFF, CTRL={prescale=CNT_RESET_PRESCALE, ie=0, en=0}, IRQ=0, irq_o=0, prescaler=0.
- Reset mid-transaction: the pending ack is dropped, all state returns to reset values, and no conf_udp pulse is issued.
- Register map (word offsets from BASE_ADDRESS):
  - 0x00+4i: CFG_i, RW, drives conf_out slice i.
  - 0x40+4i: STAT_i, RO, reads conf_in slice i sampled at the read.
  - 0x80: CNT, RW.
  - 0x84: CMP, RW.
  - 0x88: CTRL, RW. bit0 en, bit1 ie, bits[15:8] prescale; other bits read 0.
  - 0x8C: IRQ, bit0 match, write-1-to-clear.
- Decode: hit = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8]==BASE_ADDRESS[31:8]). wb_adr_i[1:0] are ignored.
- Holes in the window (channel index >= NUM_CHANNELS, or unlisted offsets):
  - Acked normally.
  - Reads return 0.
  - Writes are discarded.
- Addresses outside the window are never acked.
- Handshake (classic, single-beat):
  - wb_ack_o is registered: wb_ack_o <= hit & ~wb_ack_o.
  - Latency is 1 cycle, and ack is high for exactly 1 cycle.
  - Because of the ~wb_ack_o term, a stb held across the ack cycle does not produce a second ack. A new request is accepted the cycle after the ack.
- Writes:
  - Committed on the accepting edge, i.e. the cycle hit & ~wb_ack_o.
  - Each byte lane n is updated only if wb_sel_i[n]=1.
  - A CFG_i write with sel=0 still acks and still pulses conf_udp[i].
- conf_udp[i]: registered, high for exactly the cycle that the new conf_out slice i is first visible, coincident with wb_ack_o.
- Reads: wb_dat_o is registered on the accepting edge and is valid while wb_ack_o=1. It holds its value otherwise.
- Timer prescaler and count:
  - When en=1, the prescaler counts 0..prescale and wraps.
  - On each wrap, CNT increments. CNT wraps from 32'hFFFF_FFFF to 0.
  - When en=0, the prescaler is held at 0 and CNT is frozen.
  - With prescale=0, CNT increments every cycle.
- Match: match sets IRQ.bit0 when an increment makes CNT equal to CMP. A software write to CNT or CMP that creates equality does not set match.
- Simultaneous events:
  - A bus write to CNT overrides the increment in the same cycle; the written value is loaded and the prescaler is reset to 0.
  - A match set and a W1C in the same cycle: the set wins.
  - A CTRL write changing prescale takes effect from the next cycle; the prescaler is not reset.
- irq_o is registered: irq_o = IRQ.bit0 & ie, visible one cycle after either term changes.

Test Plan:
1. Reset then read all map offsets -> CFG/CNT/IRQ read 0, CMP reads FFFF_FFFF; reads at 0x40+4i return the driven conf_in values; each access acked after 1 cycle, exactly once.
2. Write CFG_1=32'hA5A5_5A5A with sel=4'b0101 after CFG_1=0 -> conf_out[63:32]=32'h00A5_005A; conf_udp=4'b0010 for 1 cycle, coincident with ack; conf_udp[0,2,3] stay 0.
3. Write offsets 0x10 and 0xF0 with NUM_CHANNELS=4, then read them -> both acked, reads return 0, conf_out unchanged, no conf_udp. Access to BASE+0x100 -> no ack for 10 cycles.
4. CTRL={prescale=3, ie=1, en=1}, CMP=5 -> CNT increments every 4 cycles; IRQ.bit0 sets on the step 4->5; irq_o rises 1 cycle later; W1C to IRQ clears both.
5. CNT=FFFF_FFFE, prescale=0, en=1 -> reads FFFF_FFFF, then 0, then 1 on consecutive cycles. Bus write CNT=7 in an increment cycle -> CNT=7, not 8.
6. Assert wb_rst_i during a pending write to CFG_0 -> no ack, conf_out=0, no conf_udp pulse; all registers at reset values on the next cycle.
